// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: remote end of the host serial link. Receives 8N1 command
// frames on rx_pin, issues one 32-bit bus write or read as a bus master, and
// returns ACK / read data / NAK on tx_pin.
//   clk, rst        : clock, async active-low reset
//   rx_pin, tx_pin  : serial in (async) / serial out (idle high)
//   mem_req_o/we_o/addr_o/data_o, mem_data_i, mem_gnt_i : bus master port
//   busy_o          : frame in progress (first cmd byte .. last resp stop bit)
module uart_bus_bridge #(
  parameter logic [15:0] BAUD_DIV = 16'd433,
  parameter logic [31:0] TIMEOUT  = 32'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  output logic        tx_pin,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_gnt_i,
  output logic        busy_o
);
  localparam logic [15:0] HALF = BAUD_DIV >> 1;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  rx_st_t      rx_st;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_vld, rx_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      rx_st <= R_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
      rx_vld <= 1'b0; rx_err <= 1'b0;
    end else begin
      rx_s1 <= rx_pin; rx_s2 <= rx_s1; rx_prev <= rx_s2;
      rx_vld <= 1'b0; rx_err <= 1'b0;
      case (rx_st)
        R_IDLE: if (rx_prev && !rx_s2) begin rx_st <= R_START; rx_cnt <= '0; end
        R_START:
          if (rx_cnt == HALF) begin
            // line back high at the start-bit centre: a glitch, drop it
            rx_cnt <= '0; rx_bit <= '0;
            rx_st  <= rx_s2 ? R_IDLE : R_DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        R_DATA:
          if (rx_cnt == BAUD_DIV) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= R_STOP;
          end else rx_cnt <= rx_cnt + 16'd1;
        R_STOP:
          if (rx_cnt == BAUD_DIV) begin
            rx_cnt <= '0;
            rx_vld <= rx_s2;
            rx_err <= !rx_s2;
            rx_st  <= R_IDLE;
          end else rx_cnt <= rx_cnt + 16'd1;
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_BUS, S_RESP, S_NAK} st_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
  st_t         st;
  tx_st_t      tx_st;
  logic        is_wr;
  logic [1:0]  bcnt;
  logic [31:0] addr_sh, data_sh, to_cnt, resp_sh;
  logic [2:0]  resp_left;
  logic [15:0] tx_cnt;
  logic        tx_take;

  // TX pulls the next response byte when idle or at the end of a stop bit,
  // which keeps multi-byte responses gap-free.
  assign tx_take = (tx_st == T_IDLE || (tx_st == T_STOP && tx_cnt == BAUD_DIV))
                   && resp_left != 3'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= S_CMD; is_wr <= 1'b0; bcnt <= '0;
      addr_sh <= '0; data_sh <= '0; to_cnt <= '0;
      resp_sh <= '0; resp_left <= '0;
      mem_req_o <= 1'b0; mem_we_o <= 1'b0; mem_addr_o <= '0; mem_data_o <= '0;
      busy_o <= 1'b0;
    end else begin
      if (tx_take) begin
        resp_sh   <= resp_sh >> 8;
        resp_left <= resp_left - 3'd1;
      end
      case (st)
        S_CMD: begin
          to_cnt <= '0; bcnt <= '0;
          if (rx_err) begin
            st <= S_NAK; busy_o <= 1'b1; resp_sh <= 32'h15; resp_left <= 3'd1;
          end else if (rx_vld) begin
            busy_o <= 1'b1;
            if (rx_sh == 8'hA5 || rx_sh == 8'h5A) begin
              st <= S_ADDR; is_wr <= (rx_sh == 8'hA5);
            end else begin
              st <= S_NAK; resp_sh <= 32'h15; resp_left <= 3'd1;
            end
          end
        end
        S_ADDR, S_WDATA: begin
          if (rx_err) begin
            st <= S_NAK; resp_sh <= 32'h15; resp_left <= 3'd1;
          end else if (rx_vld) begin
            to_cnt <= '0;
            bcnt   <= bcnt + 2'd1;
            if (st == S_ADDR) addr_sh <= {rx_sh, addr_sh[31:8]};
            else              data_sh <= {rx_sh, data_sh[31:8]};
            if (bcnt == 2'd3) begin
              if (st == S_ADDR && is_wr) st <= S_WDATA;
              else begin
                // bus fields latched once here so they stay stable through grant
                st        <= S_BUS;
                mem_req_o <= 1'b1;
                mem_we_o  <= is_wr;
                if (st == S_ADDR) mem_addr_o <= {rx_sh, addr_sh[31:8]};
                else begin
                  mem_addr_o <= addr_sh;
                  mem_data_o <= {rx_sh, data_sh[31:8]};
                end
              end
            end
          end else if (to_cnt >= TIMEOUT - 32'd1) begin
            st <= S_CMD; busy_o <= 1'b0;
          end else to_cnt <= to_cnt + 32'd1;
        end
        S_BUS:
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            st        <= S_RESP;
            resp_sh   <= is_wr ? 32'h06 : mem_data_i;
            resp_left <= is_wr ? 3'd1 : 3'd4;
          end
        S_RESP, S_NAK:
          if (tx_st == T_IDLE && resp_left == 3'd0) begin
            st <= S_CMD; busy_o <= 1'b0;
          end
        default: st <= S_CMD;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic [2:0] tx_bit;
  logic [7:0] tx_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st <= T_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_byte <= '0; tx_pin <= 1'b1;
    end else begin
      case (tx_st)
        T_IDLE:
          if (tx_take) begin
            tx_pin <= 1'b0; tx_st <= T_START; tx_cnt <= '0; tx_byte <= resp_sh[7:0];
          end else tx_pin <= 1'b1;
        T_START:
          if (tx_cnt == BAUD_DIV) begin
            tx_cnt <= '0; tx_bit <= '0; tx_st <= T_DATA; tx_pin <= tx_byte[0];
          end else tx_cnt <= tx_cnt + 16'd1;
        T_DATA:
          if (tx_cnt == BAUD_DIV) begin
            tx_cnt  <= '0;
            tx_byte <= tx_byte >> 1;
            tx_bit  <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin tx_st <= T_STOP; tx_pin <= 1'b1; end
            else tx_pin <= tx_byte[1];
          end else tx_cnt <= tx_cnt + 16'd1;
        T_STOP:
          if (tx_cnt == BAUD_DIV) begin
            tx_cnt <= '0;
            if (tx_take) begin
              tx_pin <= 1'b0; tx_st <= T_START; tx_byte <= resp_sh[7:0];
            end else tx_st <= T_IDLE;
          end else tx_cnt <= tx_cnt + 16'd1;
        default: tx_st <= T_IDLE;
      endcase
    end
  end
endmodule
